// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and drives IF/ID.
// Optional build macro IF_PERF_COUNT_EN adds fetch/stall performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_valid
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        load_valid;
    logic [31:0] next_pc_aligned;
    logic        unused_next_pc_lsb;

    assign next_pc_aligned    = {next_pc[31:2], 2'b00};
    assign unused_next_pc_lsb = ^next_pc[1:0];

    assign pc              = pc_q;
    assign pc_plus_4       = pc_q + 32'd4;
    assign imem_req        = !reset && (state_q == S_FETCH);
    assign imem_addr       = pc_q;
    assign if_id_instr     = if_id_instr_q;
    assign if_id_pc_plus_4 = if_id_pc4_q;
    assign if_id_valid     = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc4_d    = hold_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        load_valid    = 1'b0;
        if (flush) begin
            pc_d          = next_pc_aligned;
            if_id_instr_d = NOP_INSTR;
            if_id_pc4_d   = 32'd0;
            if_id_valid_d = 1'b0;
            state_d       = S_FETCH;
        end else if (state_q == S_HOLD) begin
            if (!stall) begin
                if_id_instr_d = hold_instr_q;
                if_id_pc4_d   = hold_pc4_q;
                if_id_valid_d = 1'b1;
                load_valid    = 1'b1;
                pc_d          = next_pc_aligned;
                state_d       = S_FETCH;
            end
        end else if (imem_ready) begin
            if (stall) begin
                // Word arrived while decode is frozen: park it instead of losing it.
                hold_instr_d = imem_rdata;
                hold_pc4_d   = pc_plus_4;
                state_d      = S_HOLD;
            end else begin
                if_id_instr_d = imem_rdata;
                if_id_pc4_d   = pc_plus_4;
                if_id_valid_d = 1'b1;
                load_valid    = 1'b1;
                pc_d          = next_pc_aligned;
            end
        end else if (!stall) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            hold_instr_q  <= NOP_INSTR;
            hold_pc4_q    <= 32'd0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc4_q    <= hold_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (load_valid)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && !flush)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: behavioural model plus directed and random stimulus.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0040;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, imem_ready;
    logic [31:0] next_pc, imem_rdata;
    logic [31:0] pc, pc_plus_4, imem_addr, if_id_instr, if_id_pc_plus_4;
    logic        imem_req, if_id_valid;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .stall(stall), .flush(flush),
        .pc(pc), .pc_plus_4(pc_plus_4), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_valid(if_id_valid)
`ifdef IF_PERF_COUNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Behavioural model: architectural values plus a queue standing in for the hold buffer.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    bit          m_init = 1'b0;
    logic [31:0] hq_instr[$];
    logic [31:0] hq_pc4[$];
    logic [31:0] m_fcnt, m_scnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
            hq_instr.delete(); hq_pc4.delete();
            m_fcnt = 0; m_scnt = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (stall && !flush) m_scnt = m_scnt + 1;
            if (flush) begin
                m_pc = next_pc & 32'hFFFF_FFFC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
                hq_instr.delete(); hq_pc4.delete();
            end else if (hq_instr.size() != 0) begin
                if (!stall) begin
                    m_instr = hq_instr.pop_front(); m_pc4 = hq_pc4.pop_front(); m_valid = 1;
                    m_pc = next_pc & 32'hFFFF_FFFC; m_fcnt = m_fcnt + 1;
                end
            end else if (imem_ready && !stall) begin
                m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1;
                m_pc = next_pc & 32'hFFFF_FFFC; m_fcnt = m_fcnt + 1;
            end else if (imem_ready && stall) begin
                hq_instr.push_back(imem_rdata); hq_pc4.push_back(m_pc + 4);
            end else if (!stall) begin
                m_instr = NOP; m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("pc", pc, m_pc);
            chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
            chk("imem_req", {31'd0, imem_req}, {31'd0, !reset && hq_instr.size() == 0});
            chk("imem_addr", imem_addr, m_pc);
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_pc_plus_4", if_id_pc_plus_4, m_pc4);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef IF_PERF_COUNT_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
            chk("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; imem_ready = 1; next_pc = 0; imem_rdata = 32'hA000_0001;
        step(); step();
        chk("rst_pc", pc, 32'h40);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // Sequential fetch out of reset
        reset = 0; next_pc = 32'h44; imem_rdata = 32'hA000_0002;
        step();
        chk("seq_pc1", pc, 32'h44);
        chk("seq_valid", {31'd0, if_id_valid}, 32'd1);
        chk("seq_pc4", if_id_pc_plus_4, 32'h44);
        chk("seq_instr", if_id_instr, 32'hA000_0002);
        next_pc = 32'h48;
        step();
        chk("seq_pc2", pc, 32'h48);

        // Stall while memory returns: hold buffer
        flush = 1; next_pc = 32'h100;
        step();
        flush = 0; stall = 1; imem_ready = 1; imem_rdata = 32'h2008_0005;
        step();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc", pc, 32'h100);
        imem_rdata = 32'hDEAD_BEEF;
        step(); step();
        chk("hold_pc3", pc, 32'h100);
        stall = 0; next_pc = 32'h300;
        step();
        chk("rel_instr", if_id_instr, 32'h2008_0005);
        chk("rel_pc4", if_id_pc_plus_4, 32'h104);
        chk("rel_pc", pc, 32'h300);
        chk("rel_valid", {31'd0, if_id_valid}, 32'd1);

        // Flush + stall while holding
        stall = 1; imem_ready = 1; imem_rdata = 32'h1111_2222;
        step();
        flush = 1; next_pc = 32'h200;
        step();
        chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
        chk("fl_instr", if_id_instr, NOP);
        chk("fl_pc", pc, 32'h200);
        flush = 0; stall = 0; imem_ready = 0;
        #0;
        chk("fl_req", {31'd0, imem_req}, 32'd1);
        chk("fl_addr", imem_addr, 32'h200);

        // Memory not ready: bubbles with stable address
        flush = 1; next_pc = 32'h20; imem_ready = 1;
        step();
        flush = 0; imem_ready = 0; next_pc = 32'h5550;
        step();
        chk("bub_valid1", {31'd0, if_id_valid}, 32'd0);
        chk("bub_addr1", imem_addr, 32'h20);
        step();
        chk("bub_addr2", imem_addr, 32'h20);
        chk("bub_instr", if_id_instr, NOP);
        imem_ready = 1; imem_rdata = 32'h0BAD_F00D; next_pc = 32'h24;
        step();
        chk("bub_load", if_id_instr, 32'h0BAD_F00D);
        chk("bub_pc", pc, 32'h24);

        // PC wrap and alignment
        flush = 1; next_pc = 32'hFFFF_FFFC;
        step();
        flush = 0; next_pc = 32'h0;
        #0;
        chk("wrap_pc4", pc_plus_4, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        next_pc = 32'h13;
        step();
        chk("align_pc", pc, 32'h10);

`ifdef IF_PERF_COUNT_EN
        reset = 1;
        step();
        reset = 0; imem_ready = 1; stall = 0; flush = 0;
        for (int i = 0; i < 10; i++) begin
            next_pc = m_pc + 4; imem_rdata = $urandom;
            step();
        end
        stall = 1; imem_ready = 0;
        for (int i = 0; i < 4; i++) step();
        chk("perf_fetch10", perf_fetch_cnt, 32'd10);
        chk("perf_stall4", perf_stall_cnt, 32'd4);
        reset = 1;
        step();
        chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
        reset = 0; stall = 0;
`endif

        // Randomised traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            stall      = ($urandom_range(0, 9) < 3);
            imem_ready = ($urandom_range(0, 9) < 6);
            imem_rdata = $urandom;
            next_pc    = ($urandom_range(0, 3) != 0) ? m_pc + 32'd4 : 32'($urandom);
            step();
        end
        reset = 0; flush = 0; stall = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch stage directly downstream of the PC-select mux. It owns the PC register and consumes the mux's selected next PC.
- Issues instruction-memory requests with a ready handshake and produces the IF/ID pipeline register.
- Provides pc_plus_4 back to the PC-select mux. Supports decode-stage stall and branch/jump flush, and buffers one instruction when a stall arrives as memory returns data.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word written to IF/ID on bubble/flush

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
next_pc  input  32  next PC from the PC-select mux (branch/jump/pc+4 already resolved)
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  redirect taken: squash fetched instruction
pc  output  32  current PC register
pc_plus_4  output  32  pc + 4, combinational, to the PC-select mux
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (= pc)
imem_ready  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
if_id_instr  output  32  IF/ID instruction
if_id_pc_plus_4  output  32  IF/ID pc+4
if_id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Arithmetic: pc_plus_4 = pc + 32'd4, 32-bit, wraps mod 2^32 (32'hFFFF_FFFC -> 32'h0). PC load forces pc[1:0]=2'b00 (next_pc[1:0] ignored).
- Reset (sync, priority over everything): pc=RESET_PC; state=FETCH; hold buffer empty; if_id_instr=NOP_INSTR; if_id_pc_plus_4=0; if_id_valid=0. imem_req=0 while reset=1. Reset mid-handshake discards any returned word.
- States: FETCH (imem_req=1, imem_addr=pc); HOLD (imem_req=0, one instruction in hold buffer).
- Priority per cycle: reset > flush > stall > normal.
- flush=1 (any state): pc<=next_pc; if_id_valid<=0; if_id_instr<=NOP_INSTR; if_id_pc_plus_4<=0; hold buffer discarded; state<=FETCH. Any imem_rdata returned that cycle is dropped. Flush overrides stall.
- FETCH, ready=1, stall=0: pc<=next_pc; if_id_instr<=imem_rdata; if_id_pc_plus_4<=pc+4; if_id_valid<=1. This gives one instruction per cycle with 1-cycle latency from ready to IF/ID.
- FETCH, ready=1, stall=1: hold_instr<=imem_rdata; hold_pc4<=pc+4; state<=HOLD. pc and IF/ID unchanged.
- FETCH, ready=0, stall=0: bubble. if_id_valid<=0; if_id_instr<=NOP_INSTR; pc unchanged; request stays asserted with the same address.
- FETCH, ready=0, stall=1: pc and IF/ID unchanged.
- HOLD, stall=1: no change; imem_req=0.
- HOLD, stall=0: IF/ID<=hold buffer with valid=1; pc<=next_pc; state<=FETCH.
- imem_addr must stay stable while imem_req=1 and imem_ready=0.
- Upstream computes next_pc from pc_plus_4 and branch/jump targets; this block samples next_pc only on advance or flush.

Optional Feature:
IF_PERF_COUNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each instruction loaded into IF/ID with valid=1.
  - perf_stall_cnt increments on each cycle with stall=1 and flush=0.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, imem_ready=1 constant, next_pc=pc_plus_4 -> pc sequence 0x40, 0x44, 0x48; if_id_valid=1 from the 2nd cycle after reset release; if_id_pc_plus_4=0x44 for the first instruction.
- Fetch at pc=0x100 with ready=1 and stall=1, held 3 cycles, rdata=32'h2008_0005 -> state HOLD, imem_req=0, pc stays 0x100; on stall drop, if_id_instr=32'h2008_0005, if_id_pc_plus_4=0x104, pc<=next_pc.
- Flush=1 together with stall=1 in HOLD, next_pc=0x200 -> if_id_valid=0, if_id_instr=NOP_INSTR, pc=0x200, hold discarded, imem_req=1 with imem_addr=0x200 next cycle.
- imem_ready held low 2 cycles at pc=0x20 -> if_id_valid=0 bubbles, imem_addr stable at 0x20; ready=1 then loads the instruction and pc advances.
- pc=32'hFFFF_FFFC, next_pc=pc_plus_4 -> pc_plus_4=0, pc wraps to 0; next_pc=32'h0000_0013 -> pc=0x10.
- With IF_PERF_COUNT_EN, 10 fetches plus 4 stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=4; reset clears both.
